mig_eval: RTL and testbench
===========================

MIG_EVAL -- requirements
Module: mig_eval

Interface
REQ-001 Parameter NUM_IN, default 7: number of primary inputs, range 3..16.
REQ-002 Parameter MAX_NODES, default 16: node-program depth, range 1..64.
REQ-003 Derived constant SEL_W = clog2(1+NUM_IN+MAX_NODES); NODE_W = 3*(SEL_W+1).
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cfg_we  in  1  write one node word into the program memory.
REQ-007 cfg_addr  in  clog2(MAX_NODES)  node index written.
REQ-008 cfg_data  in  NODE_W  three operands; each is {inv, sel[SEL_W-1:0]}; operand 0 in the LSBs.
REQ-009 cfg_len_we  in  1  load the node count and the output-inversion bit.
REQ-010 cfg_len  in  clog2(MAX_NODES+1)  number of active nodes, 0..MAX_NODES.
REQ-011 cfg_out_inv  in  1  complement the final result.
REQ-012 in_valid  in  1  input vector offered.
REQ-013 in_ready  out  1  block can accept a vector.
REQ-014 in_x  in  NUM_IN  primary input vector; bit i is x_i.
REQ-015 out_valid  out  1  result available.
REQ-016 out_ready  in  1  consumer accepts the result.
REQ-017 out_y  out  1  evaluated function value.
REQ-018 out_err  out  1  the program made an illegal operand reference during this evaluation.

Function
REQ-019 Operand sel encoding:
- 0 is constant 0.
- 1..NUM_IN is x[sel-1].
- NUM_IN+1+k is the result of node k.
- The operand value is XORed with its inv bit.
REQ-020 Node k result is MAJ(a,b,c) = ab|ac|bc of its three resolved operands.
REQ-021 States: IDLE, EVAL, DONE; in_ready=1 only in IDLE.
REQ-022 IDLE -> EVAL on in_valid&in_ready:
- in_x is registered.
- The node index is cleared to 0.
- All node-result bits are cleared.
- out_err is cleared.
REQ-023 EVAL evaluates exactly one node per cycle, in index order 0..cfg_len-1.
REQ-024 EVAL -> DONE after node cfg_len-1 is evaluated.
REQ-025 Latency: a vector accepted at edge t gives out_valid=1 after edge t+cfg_len+1.
REQ-026 DONE: out_valid=1, out_y = node[cfg_len-1] XOR out_inv.
REQ-027 out_y and out_err are held stable while out_valid=1 and out_ready=0.
REQ-028 DONE -> IDLE on out_ready; a new vector can be accepted on the next edge (one-bubble throughput).
REQ-029 cfg_len=0: IDLE -> DONE directly; out_y = out_inv; latency 1.
REQ-030 Illegal operand reference:
- Covers sel referencing node j>=k while evaluating node k, and sel > NUM_IN+MAX_NODES.
- The operand reads 0 before inversion.
- out_err is set and stays sticky until the next accept.
REQ-031 cfg_we and cfg_len_we are honoured only in IDLE and are ignored otherwise.
REQ-032 When in_valid and cfg_len_we are both active in IDLE in the same cycle:
- The vector is accepted.
- The evaluation uses the old cfg_len.
- The new value applies from the next evaluation.
REQ-033 Program memory and length are not modified by evaluation.

Reset
REQ-034 rst_n low, asynchronously:
- State goes to IDLE.
- out_valid=0, out_y=0, out_err=0.
- cfg_len=0, out_inv=0.
- Node results are cleared.
REQ-035 Program-memory contents are not reset and are undefined until written.
REQ-036 Reset mid-EVAL or mid-DONE aborts the evaluation with no output handshake; in_ready=1 on the first edge after release.

Structure
REQ-037 The shared package mig_pkg holds:
- The state enum.
- The operand struct {inv, sel}.
- The node-word struct.
- The SEL_W/NODE_W computation functions.
REQ-038 Sub-module mig_node_alu (combinational) resolves three operands and returns the majority plus an illegal-reference flag.
REQ-039 Program memory is a register array of MAX_NODES x NODE_W with one write port and one read port.

Verification
REQ-040 Program the 5-node network, defaults NUM_IN=7, out_inv=0:
- n0=MAJ(x0,x3,x4), n1=MAJ(x1,x2,x5), n2=MAJ(x0,x1,x2), n3=MAJ(x0,x6,n2), n4=MAJ(n0,n1,n3); cfg_len=5.
- in_x=7'b0000011 gives out_y=0; in_x=7'b1001001 gives out_y=1.
- In both cases out_valid rises 6 cycles after accept and out_err=0.
REQ-041 Same program, all 128 vectors against a software majority model:
- Zero mismatches.
- Random out_ready stalls keep out_y stable.
REQ-042 Same program with cfg_out_inv=1 and in_x=7'b1001001 gives out_y=0.
REQ-043 Forward reference at node 2 (operand sel = NUM_IN+1+3): out_err=1 at DONE; the next legal evaluation shows out_err=0.
REQ-044 Length and config-write timing:
- cfg_len=0 with out_inv=1 gives out_y=1 one cycle after accept.
- A cfg_we during EVAL leaves the memory unchanged, checked by re-running REQ-040.
REQ-045 Assert rst_n low at cycle 3 of EVAL: out_valid stays 0, in_ready=1 after release, and cfg_len reads back as 0 (no output without reprogramming).

Source files
------------

// File: rtl/mig_pkg.sv
// Shared types and sizing helpers for the majority-inverter-graph evaluator.
package mig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widest selector across the legal parameter range (16 inputs, 64 nodes -> 81 codes).
    // Narrower configurations zero-extend into this field.
    localparam int MAX_SEL_W = 7;

    typedef struct packed {
        logic                 inv;
        logic [MAX_SEL_W-1:0] sel;
    } operand_t;

    typedef struct packed {
        operand_t [2:0] op;
    } node_t;

    // Selector codes: constant 0, the primary inputs, then one per node result.
    function automatic int calc_sel_w(input int num_in, input int max_nodes);
        return $clog2(1 + num_in + max_nodes);
    endfunction

    function automatic int calc_node_w(input int num_in, input int max_nodes);
        return 3 * (calc_sel_w(num_in, max_nodes) + 1);
    endfunction

endpackage

// File: rtl/mig_eval_alu.sv
// Combinational node evaluator: resolves three operands, returns their majority
// and whether any operand referenced a node that is not yet evaluated or does not exist.
module mig_node_alu
    import mig_pkg::*;
#(
    parameter int NUM_IN    = 7,
    parameter int MAX_NODES = 16,
    parameter int AW        = 4
) (
    input  node_t                node,
    input  logic [NUM_IN-1:0]    x,
    input  logic [MAX_NODES-1:0] nres,
    input  logic [AW-1:0]        k,
    output logic                 maj,
    output logic                 illegal
);

    logic [2:0] val;
    logic [2:0] ill;

    // Operand resolution; illegal references read as 0 before the inversion is applied.
    always_comb begin
        val = '0;
        ill = '0;
        for (int o = 0; o < 3; o++) begin
            if (int'(node.op[o].sel) > NUM_IN + MAX_NODES)
                ill[o] = 1'b1;
            for (int i = 0; i < NUM_IN; i++)
                if (int'(node.op[o].sel) == i + 1)
                    val[o] = x[i];
            for (int j = 0; j < MAX_NODES; j++)
                if (int'(node.op[o].sel) == NUM_IN + 1 + j) begin
                    if (j < int'(k))
                        val[o] = nres[j];
                    else
                        ill[o] = 1'b1;
                end
            val[o] = val[o] ^ node.op[o].inv;
        end
    end

    assign maj     = (val[0] & val[1]) | (val[0] & val[2]) | (val[1] & val[2]);
    assign illegal = |ill;

endmodule

// File: rtl/mig_eval.sv
// Majority-inverter-graph evaluator: a programmable node list is walked one node
// per cycle against a registered input vector, producing one result bit per vector.
module mig_eval
    import mig_pkg::*;
#(
    parameter int  NUM_IN    = 7,
    parameter int  MAX_NODES = 16,
    localparam int SEL_W     = calc_sel_w(NUM_IN, MAX_NODES),
    localparam int NODE_W    = calc_node_w(NUM_IN, MAX_NODES),
    localparam int AW        = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1,
    localparam int LW        = $clog2(MAX_NODES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [NODE_W-1:0] cfg_data,
    input  logic              cfg_len_we,
    input  logic [LW-1:0]     cfg_len,
    input  logic              cfg_out_inv,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_IN-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_y,
    output logic              out_err
);

    state_t               state;
    logic [NODE_W-1:0]    mem [MAX_NODES];
    logic [LW-1:0]        cfg_len_q;
    logic                 out_inv_q;
    logic [LW-1:0]        run_len;   // length snapshot taken at accept
    logic                 run_inv;
    logic [AW-1:0]        idx;
    logic [NUM_IN-1:0]    xq;
    logic [MAX_NODES-1:0] nres;
    logic                 last;      // result of the most recently evaluated node
    logic                 err;
    logic [NODE_W-1:0]    rd_word;
    node_t                cur;
    logic                 maj;
    logic                 illegal;

    assign in_ready = (state == ST_IDLE);
    assign out_err  = err;
    assign rd_word  = mem[idx];

    // Program memory: single write port, not reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (cfg_we && state == ST_IDLE)
            mem[cfg_addr] <= cfg_data;
    end

    // Unpack the packed node word into the operand struct, zero-extending selectors.
    always_comb begin
        cur = '0;
        for (int o = 0; o < 3; o++) begin
            cur.op[o].inv              = rd_word[o*(SEL_W+1) + SEL_W];
            cur.op[o].sel[SEL_W-1:0]   = rd_word[o*(SEL_W+1) +: SEL_W];
        end
    end

    mig_node_alu #(
        .NUM_IN    (NUM_IN),
        .MAX_NODES (MAX_NODES),
        .AW        (AW)
    ) u_alu (
        .node    (cur),
        .x       (xq),
        .nres    (nres),
        .k       (idx),
        .maj     (maj),
        .illegal (illegal)
    );

    // Control FSM. DONE spends one cycle registering the result before raising
    // out_valid, then holds it until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cfg_len_q <= '0;
            out_inv_q <= 1'b0;
            run_len   <= '0;
            run_inv   <= 1'b0;
            idx       <= '0;
            xq        <= '0;
            nres      <= '0;
            last      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_len_we) begin
                        cfg_len_q <= cfg_len;
                        out_inv_q <= cfg_out_inv;
                    end
                    // A same-cycle length load only affects later vectors.
                    if (in_valid) begin
                        xq      <= in_x;
                        idx     <= '0;
                        nres    <= '0;
                        last    <= 1'b0;
                        err     <= 1'b0;
                        run_len <= cfg_len_q;
                        run_inv <= out_inv_q;
                        state   <= (cfg_len_q == '0) ? ST_DONE : ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    nres[idx] <= maj;
                    last      <= maj;
                    if (illegal)
                        err <= 1'b1;
                    if (LW'(idx) + LW'(1) == run_len)
                        state <= ST_DONE;
                    else
                        idx <= idx + 1'b1;
                end
                ST_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_y     <= last ^ run_inv;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mig_eval.sv
// Directed bench for mig_eval: 5-node reference network, exhaustive sweep with
// output stalls, inversion, zero length, config timing, illegal references, reset.
module tb_mig_eval;

    localparam int NUM_IN    = 7;
    localparam int MAX_NODES = 16;
    localparam int AW        = 4;
    localparam int LW        = 5;
    localparam int NODE_W    = 18;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [NODE_W-1:0] cfg_data = '0;
    logic              cfg_len_we = 1'b0;
    logic [LW-1:0]     cfg_len = '0;
    logic              cfg_out_inv = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NUM_IN-1:0] in_x = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_y;
    logic              out_err;

    int tests = 0;
    int fails = 0;

    mig_eval #(.NUM_IN(NUM_IN), .MAX_NODES(MAX_NODES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_len_we  (cfg_len_we),
        .cfg_len     (cfg_len),
        .cfg_out_inv (cfg_out_inv),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Reference network evaluated directly in software.
    function automatic logic model(input logic [6:0] x);
        logic n0, n1, n2, n3;
        n0 = maj3(x[0], x[3], x[4]);
        n1 = maj3(x[1], x[2], x[5]);
        n2 = maj3(x[0], x[1], x[2]);
        n3 = maj3(x[0], x[6], n2);
        return maj3(n0, n1, n3);
    endfunction

    task automatic put_node(input int a, input int s0, input int i0, input int s1, input int i1,
                            input int s2, input int i2);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = {1'(i2), 5'(s2), 1'(i1), 5'(s1), 1'(i0), 5'(s0)};
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic set_len(input int len, input logic inv);
        @(negedge clk);
        cfg_len_we  = 1'b1;
        cfg_len     = LW'(len);
        cfg_out_inv = inv;
        @(negedge clk);
        cfg_len_we  = 1'b0;
    endtask

    task automatic program_ref();
        put_node(0, 1, 0, 4, 0, 5, 0);
        put_node(1, 2, 0, 3, 0, 6, 0);
        put_node(2, 1, 0, 2, 0, 3, 0);
        put_node(3, 1, 0, 7, 0, 10, 0);
        put_node(4, 8, 0, 9, 0, 11, 0);
    endtask

    // Offer a vector and return just after the accepting edge.
    task automatic accept(input logic [6:0] x, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        in_x     = x;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // lat = number of edges after the accepting edge before out_valid is seen.
    task automatic wait_valid(output int lat, output bit ok);
        lat = -1;
        ok  = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    // Hold out_ready low for 'stall' cycles watching the result, then take it.
    task automatic pop(input int stall, output bit stable);
        logic y0, e0;
        y0 = out_y;
        e0 = out_err;
        stable = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            if (out_y !== y0 || out_err !== e0 || out_valid !== 1'b1) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_vec(input logic [6:0] x, input int stall, output logic y, output logic e,
                           output int lat, output bit ok, output bit stable);
        bit a_ok;
        accept(x, a_ok);
        lat = -1;
        ok = 1'b0;
        stable = 1'b0;
        y = 1'bx;
        e = 1'bx;
        if (a_ok) begin
            wait_valid(lat, ok);
            y = out_y;
            e = out_err;
            if (ok) pop(stall, stable);
        end
    endtask

    task automatic test_reset();
        logic y, e; int lat; bit ok, st;
        #12;
        tests++;
        if (out_valid !== 1'b0 || out_y !== 1'b0 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b y=%b e=%b, need 0 0 0", out_valid, out_y, out_err);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, need 1", in_ready);
        end
        run_vec(7'h7f, 0, y, e, lat, ok, st);
        tests++;
        if (!ok || lat != 1 || y !== 1'b0 || e !== 1'b0) begin
            fails++;
            $display("FAIL reset_len_zero: got ok=%0d lat=%0d y=%b e=%b, need 1 1 0 0", ok, lat, y, e);
        end
    endtask

    task automatic test_basic();
        logic y, e; int lat; bit ok, st;
        logic [6:0] xs [2];
        logic       ys [2];
        xs[0] = 7'b0000011; ys[0] = 1'b0;
        xs[1] = 7'b1001001; ys[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_vec(xs[i], 0, y, e, lat, ok, st);
            tests++;
            if (!ok || y !== ys[i] || e !== 1'b0 || lat != 6) begin
                fails++;
                $display("FAIL basic_%0d: got ok=%0d y=%b e=%b lat=%0d, need 1 %b 0 6", i, ok, y, e, lat, ys[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic y, e; int lat; bit ok, st;
        int bad, unstable;
        bad = 0;
        unstable = 0;
        for (int v = 0; v < 128; v++) begin
            run_vec(7'(v), int'($urandom_range(0, 3)), y, e, lat, ok, st);
            if (!ok || y !== model(7'(v)) || e !== 1'b0) begin
                bad++;
                $display("FAIL sweep_x%0d: got ok=%0d y=%b e=%b, need 1 %b 0", v, ok, y, e, model(7'(v)));
            end
            if (ok && !st) unstable++;
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (unstable != 0) begin
            fails++;
            $display("FAIL sweep_stall_stable: got %0d unstable holds, need 0", unstable);
        end
    endtask

    task automatic test_out_inv();
        logic y, e; int lat; bit ok, st;
        set_len(5, 1'b1);
        run_vec(7'b1001001, 2, y, e, lat, ok, st);
        tests++;
        if (!ok || y !== 1'b0 || e !== 1'b0) begin
            fails++;
            $display("FAIL out_inv: got ok=%0d y=%b e=%b, need 1 0 0", ok, y, e);
        end
        set_len(5, 1'b0);
    endtask

    task automatic test_len_zero();
        logic y, e; int lat; bit ok, st;
        set_len(0, 1'b1);
        run_vec(7'b0000000, 0, y, e, lat, ok, st);
        tests++;
        if (!ok || lat != 1 || y !== 1'b1 || e !== 1'b0) begin
            fails++;
            $display("FAIL len_zero: got ok=%0d lat=%0d y=%b e=%b, need 1 1 1 0", ok, lat, y, e);
        end
        set_len(5, 1'b0);
    endtask

    task automatic test_simul_len();
        logic y, e; int lat; bit ok, st;
        @(negedge clk);
        in_x        = 7'b1001001;
        in_valid    = 1'b1;
        cfg_len_we  = 1'b1;
        cfg_len     = '0;
        cfg_out_inv = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL simul_ready: got %b, need 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        cfg_len_we = 1'b0;
        wait_valid(lat, ok);
        y = out_y;
        tests++;
        if (!ok || lat != 6 || y !== 1'b1) begin
            fails++;
            $display("FAIL simul_old_len: got ok=%0d lat=%0d y=%b, need 1 6 1", ok, lat, y);
        end
        if (ok) pop(0, st);
        run_vec(7'b1001001, 0, y, e, lat, ok, st);
        tests++;
        if (!ok || lat != 1 || y !== 1'b1) begin
            fails++;
            $display("FAIL simul_new_len: got ok=%0d lat=%0d y=%b, need 1 1 1", ok, lat, y);
        end
        set_len(5, 1'b0);
    endtask

    task automatic test_cfg_during_eval();
        logic y, e; int lat; bit ok, st;
        accept(7'b1001001, ok);
        @(negedge clk);
        cfg_we     = 1'b1;
        cfg_addr   = 4'd4;
        cfg_data   = '0;
        cfg_len_we = 1'b1;
        cfg_len    = '0;
        @(negedge clk);
        cfg_we     = 1'b0;
        cfg_len_we = 1'b0;
        wait_valid(lat, ok);
        y = out_y;
        tests++;
        if (!ok || y !== 1'b1) begin
            fails++;
            $display("FAIL cfg_eval_result: got ok=%0d y=%b, need 1 1", ok, y);
        end
        if (ok) pop(0, st);
        run_vec(7'b1001001, 0, y, e, lat, ok, st);
        tests++;
        if (!ok || y !== 1'b1 || lat != 6 || e !== 1'b0) begin
            fails++;
            $display("FAIL cfg_eval_rerun_a: got ok=%0d y=%b lat=%0d e=%b, need 1 1 6 0", ok, y, lat, e);
        end
        run_vec(7'b0000011, 0, y, e, lat, ok, st);
        tests++;
        if (!ok || y !== 1'b0 || lat != 6) begin
            fails++;
            $display("FAIL cfg_eval_rerun_b: got ok=%0d y=%b lat=%0d, need 1 0 6", ok, y, lat);
        end
    endtask

    task automatic test_illegal();
        logic y, e; int lat; bit ok, st;
        // Node 2 reads node 3 before it exists.
        put_node(2, 1, 0, 2, 0, 11, 0);
        run_vec(7'b1001001, 1, y, e, lat, ok, st);
        tests++;
        if (!ok || e !== 1'b1 || y !== 1'b1 || !st) begin
            fails++;
            $display("FAIL fwd_ref: got ok=%0d e=%b y=%b st=%0d, need 1 1 1 1", ok, e, y, st);
        end
        put_node(2, 1, 0, 2, 0, 3, 0);
        run_vec(7'b1001001, 0, y, e, lat, ok, st);
        tests++;
        if (!ok || e !== 1'b0 || y !== 1'b1) begin
            fails++;
            $display("FAIL fwd_ref_clear: got ok=%0d e=%b y=%b, need 1 0 1", ok, e, y);
        end
        // Out-of-range selector reads 0, inverted to 1: node0 = MAJ(1, 0, x0) = x0.
        put_node(0, 31, 1, 0, 0, 1, 0);
        set_len(1, 1'b0);
        run_vec(7'b0000001, 0, y, e, lat, ok, st);
        tests++;
        if (!ok || e !== 1'b1 || y !== 1'b1 || lat != 2) begin
            fails++;
            $display("FAIL range_ref_1: got ok=%0d e=%b y=%b lat=%0d, need 1 1 1 2", ok, e, y, lat);
        end
        run_vec(7'b0000000, 0, y, e, lat, ok, st);
        tests++;
        if (!ok || e !== 1'b1 || y !== 1'b0) begin
            fails++;
            $display("FAIL range_ref_0: got ok=%0d e=%b y=%b, need 1 1 0", ok, e, y);
        end
        put_node(0, 1, 0, 4, 0, 5, 0);
        set_len(5, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic y, e; int lat; bit ok, st;
        bit seen;
        accept(7'b1001001, ok);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL reset_mid_valid: got out_valid=1 during reset, need 0");
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_ready: got rdy=%b v=%b, need 1 0", in_ready, out_valid);
        end
        run_vec(7'b1001001, 0, y, e, lat, ok, st);
        tests++;
        if (!ok || lat != 1 || y !== 1'b0 || e !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_len: got ok=%0d lat=%0d y=%b e=%b, need 1 1 0 0", ok, lat, y, e);
        end
    endtask

    initial begin
        test_reset();
        program_ref();
        set_len(5, 1'b0);
        test_basic();
        test_exhaustive();
        test_out_inv();
        test_len_zero();
        test_simul_len();
        test_cfg_during_eval();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
